// File: rtl/audio_sample_packet_decoder.sv
// HDMI audio sample packet decoder: unpacks data-island subpackets into a
// left/right PCM stream and accumulates IEC 60958 channel-status blocks.
module audio_sample_packet_decoder #(
  parameter int AUDIO_BIT_WIDTH = 16
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       packet_valid,
  output logic                       packet_ready,
  input  logic [23:0]                header,
  input  logic [223:0]               sub,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word_left,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_sample_word_right,
  output logic                       audio_valid,
  input  logic                       audio_ready,
  output logic [191:0]               channel_status_left,
  output logic [191:0]               channel_status_right,
  output logic                       channel_status_valid,
  output logic [3:0]                 word_length,
  output logic [4:0]                 decoded_bit_width,
  output logic [3:0]                 sampling_frequency,
  output logic                       parity_error,
  output logic                       block_error
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_EMIT    = 1'b1;
  localparam logic [7:0] LAST_FRAME = 8'd191;

  function automatic logic [1:0] lowest_set(input logic [3:0] bits);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bits[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur.
  function automatic logic [2:0] next_set(input logic [3:0] bits, input logic [1:0] cur);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (bits[i] && (i > int'(cur))) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [55:0] pick(input logic [223:0] s, input logic [1:0] i);
    logic [55:0] r;
    case (i)
      2'd0:    r = s[55:0];
      2'd1:    r = s[111:56];
      2'd2:    r = s[167:112];
      2'd3:    r = s[223:168];
      default: r = 56'd0;
    endcase
    return r;
  endfunction

  // Even parity over a 24-bit sample and its V/U/C/P bits; 1 means bad.
  function automatic logic chan_parity_bad(input logic [23:0] s, input logic [3:0] vucp);
    return ^{s, vucp};
  endfunction

  function automatic logic [4:0] width_of(input logic [3:0] wl);
    logic [4:0] r;
    case (wl)
      4'b0010: r = 5'd16;
      4'b1010: r = 5'd20;
      4'b1011: r = 5'd24;
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [0:0]                 state_r;
  logic [1:0]                 idx_r;
  logic [3:0]                 present_r;
  logic [3:0]                 b_flags_r;
  logic [223:0]               sub_r;
  logic                       packet_ready_r;
  logic                       audio_valid_r;
  logic [AUDIO_BIT_WIDTH-1:0] word_left_r;
  logic [AUDIO_BIT_WIDTH-1:0] word_right_r;
  logic [7:0]                 fc_r;
  logic                       synced_r;
  logic [191:0]               acc_l_r;
  logic [191:0]               acc_r_r;
  logic [191:0]               cs_left_r;
  logic [191:0]               cs_right_r;
  logic                       cs_valid_r;
  logic [3:0]                 word_length_r;
  logic [4:0]                 bit_width_r;
  logic [3:0]                 samp_freq_r;
  logic                       parity_error_r;
  logic                       block_error_r;

  logic        accept_s;
  logic        pkt_ok_s;
  logic        hs_s;
  logic [1:0]  first_idx_s;
  logic [2:0]  nxt_s;
  logic [55:0] cur_sub_s;
  logic [55:0] new_sub_s;
  logic [55:0] adv_sub_s;
  logic        b_cur_s;

  assign accept_s    = packet_valid && packet_ready_r;
  assign pkt_ok_s    = (header[7:0] == 8'h02) && !header[12] && (header[11:8] != 4'd0);
  assign hs_s        = audio_valid_r && audio_ready;
  assign first_idx_s = lowest_set(header[11:8]);
  assign nxt_s       = next_set(present_r, idx_r);
  assign cur_sub_s   = pick(sub_r, idx_r);
  assign new_sub_s   = pick(sub, first_idx_s);
  assign adv_sub_s   = pick(sub_r, nxt_s[1:0]);
  assign b_cur_s     = b_flags_r[idx_r];

  // Packet acceptance and per-subpacket sample emission.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      packet_ready_r <= 1'b1;
      audio_valid_r  <= 1'b0;
      idx_r          <= 2'd0;
      present_r      <= 4'd0;
      b_flags_r      <= 4'd0;
      sub_r          <= 224'd0;
      word_left_r    <= '0;
      word_right_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && pkt_ok_s) begin
            state_r        <= ST_EMIT;
            packet_ready_r <= 1'b0;
            audio_valid_r  <= 1'b1;
            idx_r          <= first_idx_s;
            present_r      <= header[11:8];
            b_flags_r      <= header[23:20];
            sub_r          <= sub;
            word_left_r    <= new_sub_s[23 -: AUDIO_BIT_WIDTH];
            word_right_r   <= new_sub_s[47 -: AUDIO_BIT_WIDTH];
          end
        end
        ST_EMIT: begin
          if (hs_s) begin
            if (nxt_s[2]) begin
              idx_r        <= nxt_s[1:0];
              word_left_r  <= adv_sub_s[23 -: AUDIO_BIT_WIDTH];
              word_right_r <= adv_sub_s[47 -: AUDIO_BIT_WIDTH];
            end else begin
              state_r        <= ST_IDLE;
              packet_ready_r <= 1'b1;
              audio_valid_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          packet_ready_r <= 1'b1;
          audio_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Parity check, frame counting and channel-status block accumulation.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      fc_r           <= 8'd0;
      synced_r       <= 1'b0;
      acc_l_r        <= 192'd0;
      acc_r_r        <= 192'd0;
      cs_left_r      <= 192'd0;
      cs_right_r     <= 192'd0;
      cs_valid_r     <= 1'b0;
      word_length_r  <= 4'd0;
      bit_width_r    <= 5'd0;
      samp_freq_r    <= 4'd0;
      parity_error_r <= 1'b0;
      block_error_r  <= 1'b0;
    end else begin
      cs_valid_r     <= 1'b0;
      block_error_r  <= 1'b0;
      parity_error_r <= hs_s && (chan_parity_bad(cur_sub_s[23:0], cur_sub_s[51:48]) ||
                                 chan_parity_bad(cur_sub_s[47:24], cur_sub_s[55:52]));
      if (hs_s) begin
        if (b_cur_s) begin
          block_error_r <= synced_r && (fc_r != 8'd0);
          acc_l_r[0]    <= cur_sub_s[50];
          acc_r_r[0]    <= cur_sub_s[54];
          fc_r          <= 8'd1;
          synced_r      <= 1'b1;
        end else if (synced_r) begin
          if (fc_r == 8'd0) begin
            block_error_r <= 1'b1;
            synced_r      <= 1'b0;
          end else begin
            acc_l_r[fc_r] <= cur_sub_s[50];
            acc_r_r[fc_r] <= cur_sub_s[54];
            if (fc_r == LAST_FRAME) begin
              // Bit 191 is taken straight from the current frame, not the accumulator.
              cs_left_r     <= {cur_sub_s[50], acc_l_r[190:0]};
              cs_right_r    <= {cur_sub_s[54], acc_r_r[190:0]};
              word_length_r <= acc_l_r[35:32];
              bit_width_r   <= width_of(acc_l_r[35:32]);
              samp_freq_r   <= acc_l_r[27:24];
              cs_valid_r    <= 1'b1;
              fc_r          <= 8'd0;
            end else begin
              fc_r <= fc_r + 8'd1;
            end
          end
        end else begin
          fc_r <= fc_r;
        end
      end
    end
  end

  assign packet_ready            = packet_ready_r;
  assign audio_valid             = audio_valid_r;
  assign audio_sample_word_left  = word_left_r;
  assign audio_sample_word_right = word_right_r;
  assign channel_status_left     = cs_left_r;
  assign channel_status_right    = cs_right_r;
  assign channel_status_valid    = cs_valid_r;
  assign word_length             = word_length_r;
  assign decoded_bit_width       = bit_width_r;
  assign sampling_frequency      = samp_freq_r;
  assign parity_error            = parity_error_r;
  assign block_error             = block_error_r;

endmodule

// File: tb/tb_audio_sample_packet_decoder.sv
// Scoreboard bench for audio_sample_packet_decoder: directed packets push
// expected samples/blocks into queues, a negedge monitor pops and compares.
module tb_audio_sample_packet_decoder;

  localparam int W = 16;

  typedef struct {
    logic [191:0] l;
    logic [191:0] r;
    logic [3:0]   wl;
    logic [3:0]   sf;
    logic [4:0]   bw;
  } cs_exp_t;

  logic           clk_pixel = 1'b0;
  logic           reset = 1'b1;
  logic           packet_valid = 1'b0;
  logic           packet_ready;
  logic [23:0]    header = 24'd0;
  logic [223:0]   sub = 224'd0;
  logic [W-1:0]   audio_sample_word_left;
  logic [W-1:0]   audio_sample_word_right;
  logic           audio_valid;
  logic           audio_ready = 1'b1;
  logic [191:0]   channel_status_left;
  logic [191:0]   channel_status_right;
  logic           channel_status_valid;
  logic [3:0]     word_length;
  logic [4:0]     decoded_bit_width;
  logic [3:0]     sampling_frequency;
  logic           parity_error;
  logic           block_error;

  audio_sample_packet_decoder #(.AUDIO_BIT_WIDTH(W)) dut (
    .clk_pixel(clk_pixel), .reset(reset),
    .packet_valid(packet_valid), .packet_ready(packet_ready),
    .header(header), .sub(sub),
    .audio_sample_word_left(audio_sample_word_left),
    .audio_sample_word_right(audio_sample_word_right),
    .audio_valid(audio_valid), .audio_ready(audio_ready),
    .channel_status_left(channel_status_left),
    .channel_status_right(channel_status_right),
    .channel_status_valid(channel_status_valid),
    .word_length(word_length), .decoded_bit_width(decoded_bit_width),
    .sampling_frequency(sampling_frequency),
    .parity_error(parity_error), .block_error(block_error)
  );

  always #5 clk_pixel = ~clk_pixel;

  int checks = 0;
  int errors = 0;
  int par_cnt = 0;
  int blk_cnt = 0;
  int csv_cnt = 0;
  logic [31:0] exp_q[$];
  cs_exp_t     cs_q[$];
  logic [31:0] mon_e;
  cs_exp_t     mon_c;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every sample handshake / block latch.
  always @(negedge clk_pixel) begin
    if (!reset) begin
      if (audio_valid && audio_ready) begin
        if (exp_q.size() == 0) begin
          check("sample_unexpected", {audio_sample_word_left, audio_sample_word_right}, 192'd0);
          if ({audio_sample_word_left, audio_sample_word_right} == 32'd0) begin
            errors++;
            $display("FAIL sample_unexpected actual=valid expected=none");
          end
        end else begin
          mon_e = exp_q.pop_front();
          check("sample_left", audio_sample_word_left, mon_e[31:16]);
          check("sample_right", audio_sample_word_right, mon_e[15:0]);
        end
      end
      if (parity_error) par_cnt++;
      if (block_error) blk_cnt++;
      if (channel_status_valid) begin
        csv_cnt++;
        if (cs_q.size() != 0) begin
          mon_c = cs_q.pop_front();
          check("cs_left", channel_status_left, mon_c.l);
          check("cs_right", channel_status_right, mon_c.r);
          check("word_length", word_length, mon_c.wl);
          check("cs_left_35_32", channel_status_left[35:32], mon_c.wl);
          check("decoded_bit_width", decoded_bit_width, mon_c.bw);
          check("sampling_frequency", sampling_frequency, mon_c.sf);
        end
      end
    end
  end

  function automatic logic [55:0] make_sub(input logic [23:0] l, input logic [23:0] r,
                                           input logic cl, input logic cr, input logic flip_pl);
    logic pl;
    logic pr;
    pl = (^l) ^ cl ^ flip_pl;
    pr = (^r) ^ cr;
    return {pr, cr, 1'b0, 1'b0, pl, cl, 1'b0, 1'b0, r, l};
  endfunction

  function automatic logic [191:0] make_cs(input logic [3:0] wl, input logic [3:0] sf);
    logic [191:0] cs;
    cs = 192'd0;
    cs[35:32] = wl;
    cs[27:24] = sf;
    cs[1] = 1'b1;
    cs[120] = 1'b1;
    cs[191] = 1'b1;
    return cs;
  endfunction

  task automatic send_packet(input logic [23:0] hdr, input logic [223:0] s);
    logic rdy;
    logic ok;
    ok = 1'b0;
    header = hdr;
    sub = s;
    packet_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_pixel);
      rdy = packet_ready;
      @(posedge clk_pixel);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1 packet_valid = 1'b0;
    check("packet_accepted", ok, 1'b1);
  endtask

  task automatic send_frame(input int k, input logic cl, input logic cr, input logic b,
                            input logic flip_pl);
    logic [23:0] l;
    logic [23:0] r;
    l = {8'(k), 8'hA5 ^ 8'(k), 8'h3C};
    r = {8'hC3, 8'(k * 3), 8'h81};
    exp_q.push_back({l[23:8], r[23:8]});
    send_packet({3'b000, b, 4'b0000, 8'h01, 8'h02}, {168'd0, make_sub(l, r, cl, cr, flip_pl)});
  endtask

  task automatic run_block(input logic [3:0] wl, input logic [3:0] sf, input logic [4:0] bw,
                           input int n, input logic push);
    logic [191:0] cl;
    logic [191:0] cr;
    cs_exp_t e;
    cl = make_cs(wl, sf);
    cr = cl ^ (192'd1 << 7);
    for (int k = 0; k < n; k++) begin
      if (push && k == 191) begin
        e.l = cl; e.r = cr; e.wl = wl; e.sf = sf; e.bw = bw;
        cs_q.push_back(e);
      end
      send_frame(k, cl[k], cr[k], k == 0, 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_pixel);
    #1 reset = 1'b0;
    @(negedge clk_pixel);
    check("reset_packet_ready", packet_ready, 1'b1);
    check("reset_audio_valid", audio_valid, 1'b0);
    check("reset_cs_valid", channel_status_valid, 1'b0);
    check("reset_cs_left", channel_status_left, 192'd0);
    check("reset_word_length", word_length, 4'd0);
    check("reset_bit_width", decoded_bit_width, 5'd0);
    check("reset_parity_error", parity_error, 1'b0);

    // Two-subpacket packet with downstream stall
    @(posedge clk_pixel);
    #1 audio_ready = 1'b0;
    exp_q.push_back({16'h1234, 16'hAAAA});
    exp_q.push_back({16'h5678, 16'hBBBB});
    send_packet({8'h00, 8'h0A, 8'h02},
                {make_sub(24'h567800, 24'hBBBB00, 1'b0, 1'b0, 1'b0), 56'd0,
                 make_sub(24'h123400, 24'hAAAA00, 1'b0, 1'b0, 1'b0), 56'd0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pixel);
      check("stall_audio_valid", audio_valid, 1'b1);
      check("stall_packet_ready", packet_ready, 1'b0);
      check("stall_word_left", audio_sample_word_left, 16'h1234);
    end
    @(posedge clk_pixel);
    #1 audio_ready = 1'b1;
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("mid_packet_ready", packet_ready, 1'b0);
    check("second_word_left", audio_sample_word_left, 16'h5678);
    @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("after_last_packet_ready", packet_ready, 1'b1);
    check("after_last_audio_valid", audio_valid, 1'b0);

    // Parity fault on left channel: sample still delivered
    @(posedge clk_pixel);
    #1 send_frame(7, 1'b1, 1'b0, 1'b0, 1'b1);

    // Non-audio packet is consumed and dropped
    send_packet({8'h00, 8'h01, 8'h84}, {168'd0, make_sub(24'h777700, 24'h888800, 1'b0, 1'b0, 1'b0)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pixel);
      check("drop_audio_valid", audio_valid, 1'b0);
      check("drop_packet_ready", packet_ready, 1'b1);
    end

    // Channel-status blocks for 16/20/24-bit word lengths
    @(posedge clk_pixel);
    #1 run_block(4'b0010, 4'b0010, 5'd16, 192, 1'b1);
    run_block(4'b1010, 4'b0011, 5'd20, 192, 1'b1);
    run_block(4'b1011, 4'b1110, 5'd24, 192, 1'b1);

    // Early B flag at frame 100, then a full block
    run_block(4'b0100, 4'b0000, 5'd0, 100, 1'b0);
    run_block(4'b0010, 4'b1010, 5'd16, 192, 1'b1);

    // Reset while a packet is held in EMIT
    repeat (3) @(posedge clk_pixel);
    #1 audio_ready = 1'b0;
    send_packet({8'h00, 8'h01, 8'h02}, {168'd0, make_sub(24'h999900, 24'h111100, 1'b0, 1'b0, 1'b0)});
    @(negedge clk_pixel);
    check("pre_reset_audio_valid", audio_valid, 1'b1);
    @(posedge clk_pixel);
    #1 reset = 1'b1;
    @(posedge clk_pixel);
    #1 reset = 1'b0;
    @(negedge clk_pixel);
    check("post_reset_audio_valid", audio_valid, 1'b0);
    check("post_reset_packet_ready", packet_ready, 1'b1);
    check("post_reset_cs_left", channel_status_left, 192'd0);
    check("post_reset_word_length", word_length, 4'd0);
    @(posedge clk_pixel);
    #1 audio_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pixel);
      check("post_reset_no_valid", audio_valid, 1'b0);
    end

    repeat (4) @(posedge clk_pixel);
    #1;
    check("sample_queue_drained", exp_q.size(), 0);
    check("cs_queue_drained", cs_q.size(), 0);
    check("cs_valid_count", csv_cnt, 4);
    check("parity_error_count", par_cnt, 1);
    check("block_error_count", blk_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
